// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with enable, clamped parallel load, wrap/saturate mode,
// registered carry/borrow pulses and a sticky overflow flag.
module up_down_counter_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_d;
    logic             carry_d;
    logic             borrow_d;
    logic             ovf_d;
    logic [WIDTH:0]   count_inc;
    logic [WIDTH-1:0] count_dec;

    assign at_max = (count == MAX_C);
    assign at_min = (count == '0);

    // Increment at WIDTH+1 bits so a full-range modulus never aliases.
    assign count_inc = {1'b0, count} + (WIDTH + 1)'(1);
    assign count_dec = count - WIDTH'(1);

    // Next-state: load beats count enable; limits either wrap or hold.
    always_comb begin
        count_d  = count;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (up_down) begin
                if (at_max) begin
                    carry_d = 1'b1;
                    count_d = SATURATE ? count : '0;
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                end
            end else begin
                if (at_min) begin
                    borrow_d = 1'b1;
                    count_d  = SATURATE ? count : MAX_C;
                end else begin
                    count_d = count_dec;
                end
            end
        end
        // A same-cycle event overrides the clear.
        ovf_d = carry_d | borrow_d | (ovf & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            count  <= count_d;
            carry  <= carry_d;
            borrow <= borrow_d;
            ovf    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod across three parameterisations sharing one stimulus.
module tb_up_down_counter_mod;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;
    logic       ovf_clr;

    logic [2:0] a_count;
    logic       a_carry, a_borrow, a_at_max, a_at_min, a_ovf;
    logic [3:0] b_count;
    logic       b_carry, b_borrow, b_at_max, b_at_min, b_ovf;
    logic [3:0] c_count;
    logic       c_carry, c_borrow, c_at_max, c_at_min, c_ovf;

    int vectors;
    int miscompares;

    up_down_counter_mod #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[2:0]), .ovf_clr(ovf_clr), .count(a_count), .carry(a_carry),
        .borrow(a_borrow), .at_max(a_at_max), .at_min(a_at_min), .ovf(a_ovf)
    );

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(b_count), .carry(b_carry),
        .borrow(b_borrow), .at_max(b_at_max), .at_min(b_at_min), .ovf(b_ovf)
    );

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(5), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c_count), .carry(c_carry),
        .borrow(c_borrow), .at_max(c_at_max), .at_min(c_at_min), .ovf(c_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        en       = 1'b0;
        up_down  = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        ovf_clr  = 1'b0;

        #2;
        chk("rst_count", 32'(a_count), 0);
        chk("rst_carry", 32'(a_carry), 0);
        chk("rst_borrow", 32'(a_borrow), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_at_min", 32'(a_at_min), 1);
        chk("rst_at_max", 32'(a_at_max), 0);

        @(negedge clk);
        reset = 1'b0;

        // 3-bit wrap counting up
        en      = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t1_count", 32'(a_count), 32'((i + 1) % 8));
            chk("t1_carry", 32'(a_carry), (i == 7) ? 1 : 0);
            chk("t1_ovf", 32'(a_ovf), (i >= 7) ? 1 : 0);
            chk("t1_at_max", 32'(a_at_max), (i == 6) ? 1 : 0);
        end

        // mod-10 counting down through 0
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd2;
        step();
        chk("t2_load", 32'(b_count), 2);
        load    = 1'b0;
        en      = 1'b1;
        up_down = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_count", 32'(b_count), (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 9 : 8);
            chk("t2_borrow", 32'(b_borrow), (i == 2) ? 1 : 0);
            chk("t2_at_min", 32'(b_at_min), (i == 1) ? 1 : 0);
            chk("t2_at_max", 32'(b_at_max), (i == 2) ? 1 : 0);
        end

        // saturating counter at MAX_VAL=5
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd4;
        step();
        chk("t3_load", 32'(c_count), 4);
        load    = 1'b0;
        en      = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_count", 32'(c_count), 5);
            chk("t3_carry", 32'(c_carry), (i > 0) ? 1 : 0);
        end
        up_down = 1'b0;
        step();
        chk("t3_down_count", 32'(c_count), 4);
        chk("t3_down_carry", 32'(c_carry), 0);
        chk("t3_down_borrow", 32'(c_borrow), 0);

        // load clamping and load priority over enable
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd12;
        step();
        chk("t4_clamp", 32'(b_count), 9);
        en       = 1'b1;
        up_down  = 1'b1;
        load_val = 4'd3;
        step();
        chk("t4_load_wins", 32'(b_count), 3);
        chk("t4_no_carry", 32'(b_carry), 0);

        // ovf clear alone, then clear coinciding with a carry
        chk("t5_ovf_pre", 32'(b_ovf), 1);
        load    = 1'b0;
        en      = 1'b0;
        ovf_clr = 1'b1;
        step();
        chk("t5_ovf_clr", 32'(b_ovf), 0);
        ovf_clr  = 1'b0;
        load     = 1'b1;
        load_val = 4'd9;
        step();
        chk("t5_load9", 32'(b_count), 9);
        load    = 1'b0;
        en      = 1'b1;
        ovf_clr = 1'b1;
        step();
        chk("t5_wrap", 32'(b_count), 0);
        chk("t5_carry", 32'(b_carry), 1);
        chk("t5_set_wins", 32'(b_ovf), 1);
        ovf_clr = 1'b0;
        en      = 1'b0;
        step();
        chk("t5_ovf_sticky", 32'(b_ovf), 1);
        chk("t5_carry_pulse", 32'(b_carry), 0);

        // asynchronous reset between edges
        load     = 1'b1;
        load_val = 4'd0;
        step();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t6_pre_count", 32'(a_count), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_count", 32'(a_count), 0);
        chk("t6_async_b_count", 32'(b_count), 0);
        chk("t6_async_ovf", 32'(b_ovf), 0);
        chk("t6_async_at_min", 32'(a_at_min), 1);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("t6_resume", 32'(a_count), 1);
        chk("t6_resume_carry", 32'(a_carry), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
